// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, lane widths.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  // The reserved size encoding behaves as a full word.
  function automatic lsu_size_e decode_size(input logic [1:0] s);
    case (s)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling between word memory and sub-word accesses: load extract/extend and store merge.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  lsu_size_e      size,
  input  logic           sgn,
  input  logic [1:0]     lane,
  input  logic [n-1:0]   rword,
  input  logic [n-1:0]   wdata,
  output logic [n-1:0]   load_data,
  output logic [n-1:0]   merged
);

  logic [BYTE_W-1:0] byte_v;
  logic [HALF_W-1:0] half_v;
  logic [4:0]        byte_base;
  logic [4:0]        half_base;

  always_comb begin
    byte_base = {lane, 3'b000};
    half_base = {lane[1], 4'b0000};
    byte_v    = rword[byte_base +: BYTE_W];
    half_v    = rword[half_base +: HALF_W];

    case (size)
      SZ_BYTE: load_data = {{(n-BYTE_W){sgn & byte_v[BYTE_W-1]}}, byte_v};
      SZ_HALF: load_data = {{(n-HALF_W){sgn & half_v[HALF_W-1]}}, half_v};
      default: load_data = rword;
    endcase

    merged = rword;
    case (size)
      SZ_BYTE: merged[byte_base +: BYTE_W] = wdata[BYTE_W-1:0];
      SZ_HALF: merged[half_base +: HALF_W] = wdata[HALF_W-1:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: request capture, range/alignment checks and the IDLE/READ/WRITE/RESP FSM.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of truncating.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned n = 32,
  parameter int unsigned m = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         resp_valid,
  output logic [n-1:0] resp_rdata,
  output logic         resp_err,
  output logic         mem_write_enable,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_writedata,
  input  logic [n-1:0] mem_readdata
);

  lsu_state_e   state_q, state_d;
  logic         wr_q;
  lsu_size_e    size_q;
  logic         sgn_q;
  logic [n-1:0] addr_q;
  logic [n-1:0] wdata_q;
  logic         err_q;
  logic [n-1:0] rword_q;

  lsu_size_e    size_in;
  logic         range_err;
  logic         misalign_err;
  logic         req_err;
  logic [n-1:0] addr_in;
  logic         accept;
  logic [n-1:0] load_data;
  logic [n-1:0] merged;

  always_comb begin
    size_in   = decode_size(req_size);
    range_err = |req_addr[n-1:m+2];
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_err = ((size_in == SZ_HALF) && req_addr[0]) ||
                   ((size_in == SZ_WORD) && (req_addr[1:0] != 2'b00));
    addr_in      = req_addr;
`else
    misalign_err = 1'b0;
    addr_in      = req_addr;
    if (size_in == SZ_HALF) addr_in[0]   = 1'b0;
    if (size_in == SZ_WORD) addr_in[1:0] = 2'b00;
`endif
    req_err = range_err | misalign_err;
    accept  = req_valid && (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rword_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= req_write;
        size_q  <= size_in;
        sgn_q   <= req_signed;
        addr_q  <= addr_in;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
      if (state_q == READ) rword_q <= mem_readdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                     state_d = RESP;
          else if (!req_write)             state_d = READ;
          else if (size_in == SZ_WORD)     state_d = WRITE;
          else                             state_d = READ;
        end
      end
      READ:    state_d = wr_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  lsu_align #(.n(n)) u_align (
    .size      (size_q),
    .sgn       (sgn_q),
    .lane      (addr_q[1:0]),
    .rword     (rword_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  always_comb begin
    req_ready        = (state_q == IDLE);
    resp_valid       = (state_q == RESP);
    resp_err         = (state_q == RESP) && err_q;
    resp_rdata       = ((state_q == RESP) && !wr_q && !err_q) ? load_data : '0;
    mem_write_enable = (state_q == WRITE);
    mem_addr         = ((state_q == READ) || (state_q == WRITE)) ? {addr_q[n-1:2], 2'b00} : '0;
    mem_writedata    = (state_q == WRITE) ? merged : '0;
  end

endmodule
